// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstgen.sv
// Reset generator: async assert, CLK-synchronous release after a hold,
// plus a software-reset request/acknowledge path.
module gf180mcu_fd_sc_mcu9t5v0__rstgen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic CLK,
    input  logic RN,
    input  logic SWRST_REQ,
    output logic SWRST_ACK,
    output logic RSTN_OUT,
    output logic BUSY
);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_SYNC,
        ST_HOLD,
        ST_RUN,
        ST_SWHOLD
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("rstgen: SYNC_STAGES must be 2..4");
    end

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
        $error("rstgen: HOLD_CYCLES must be 1..2^CNT_W-1");
    end

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rstn_q, rstn_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_ASSERT;
            sync_q  <= '0;
            cnt_q   <= '0;
            rstn_q  <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    // The chain advances on the same edge the last stage turns 1, so HOLD
    // starts at edge SYNC_STAGES and release lands on SYNC_STAGES+HOLD_CYCLES.
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_ASSERT, ST_SYNC: begin
                sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
                cnt_d   = '0;
                state_d = sync_d[SYNC_STAGES-1] ? ST_HOLD : ST_SYNC;
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (SWRST_REQ) begin
                    state_d = ST_SWHOLD;
                    cnt_d   = '0;
                end
            end
            ST_SWHOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                sync_d  = '0;
                cnt_d   = '0;
            end
        endcase
        rstn_d = (state_d == ST_RUN);
        busy_d = !rstn_d;
    end

    assign RSTN_OUT  = rstn_q;
    assign BUSY      = busy_q;
    assign SWRST_ACK = ack_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rstgen.sv
// Bench for the reset generator: default and (3,1) instances checked
// every cycle against an edge-counting reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__rstgen;

    localparam int S0 = 2;
    localparam int H0 = 16;
    localparam int S1 = 3;
    localparam int H1 = 1;

    typedef struct {
        int   since;
        int   sw_left;
        logic rstn;
        logic busy;
        logic ack;
    } mdl_t;

    logic clk = 1'b0;
    logic rn0 = 1'b1;
    logic rn1 = 1'b1;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic ack0, rstn0, busy0;
    logic ack1, rstn1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__rstgen #(
        .SYNC_STAGES(S0),
        .HOLD_CYCLES(H0),
        .CNT_W(5)
    ) u_def (
        .CLK(clk),
        .RN(rn0),
        .SWRST_REQ(req0),
        .SWRST_ACK(ack0),
        .RSTN_OUT(rstn0),
        .BUSY(busy0)
    );

    gf180mcu_fd_sc_mcu9t5v0__rstgen #(
        .SYNC_STAGES(S1),
        .HOLD_CYCLES(H1),
        .CNT_W(5)
    ) u_swp (
        .CLK(clk),
        .RN(rn1),
        .SWRST_REQ(req1),
        .SWRST_ACK(ack1),
        .RSTN_OUT(rstn1),
        .BUSY(busy1)
    );

    function automatic mdl_t mdl_rst();
        mdl_t m;
        m.since   = 0;
        m.sw_left = 0;
        m.rstn    = 1'b0;
        m.busy    = 1'b1;
        m.ack     = 1'b0;
        return m;
    endfunction

    // since >= 0: edges counted since RN release; -1 once released.
    function automatic mdl_t mdl_step(mdl_t m, logic req, int s, int h);
        mdl_t n = m;
        n.ack = 1'b0;
        if (m.since >= 0) begin
            n.since = m.since + 1;
            if (n.since == s + h) begin
                n.since = -1;
                n.rstn  = 1'b1;
                n.busy  = 1'b0;
            end
        end else if (m.sw_left > 0) begin
            n.sw_left = m.sw_left - 1;
            if (n.sw_left == 0) begin
                n.rstn = 1'b1;
                n.busy = 1'b0;
                n.ack  = 1'b1;
            end
        end else if (req) begin
            n.sw_left = h;
            n.rstn    = 1'b0;
            n.busy    = 1'b1;
        end
        return n;
    endfunction

    mdl_t m0 = mdl_rst();
    mdl_t m1 = mdl_rst();

    always @(posedge clk or negedge rn0) begin
        if (!rn0) m0 <= mdl_rst();
        else      m0 <= mdl_step(m0, req0, S0, H0);
    end

    always @(posedge clk or negedge rn1) begin
        if (!rn1) m1 <= mdl_rst();
        else      m1 <= mdl_step(m1, req1, S1, H1);
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_rstn0", rstn0, m0.rstn);
        chk("m_busy0", busy0, m0.busy);
        chk("m_ack0", ack0, m0.ack);
        chk("m_rstn1", rstn1, m1.rstn);
        chk("m_busy1", busy1, m1.busy);
        chk("m_ack1", ack1, m1.ack);
    end

    initial begin
        int lo0 = 0;
        int lo1 = 0;
        #1 rn0 = 1'b0;
        rn1 = 1'b0;
        #1;
        chk("rst_rstn0", rstn0, 1'b0);
        chk("rst_busy0", busy0, 1'b1);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_rstn1", rstn1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rn0 = 1'b1;
        rn1 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk("pwr_rstn0", rstn0, n >= 18);
            chk("pwr_busy0", busy0, n < 18);
            chk("pwr_rstn1", rstn1, n >= 4);
        end

        #2 req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        chk("sw_low0", rstn0, 1'b0);
        chk("sw_low1", rstn1, 1'b0);
        #2 req0 = 1'b0;
        req1 = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("sw_rel1", rstn1, 1'b1);
                chk("sw_ack1", ack1, 1'b1);
            end
            if (j == 2) chk("sw_ackfall1", ack1, 1'b0);
            if (j < 16) begin
                chk("sw_hold0", rstn0, 1'b0);
                chk("sw_noack0", ack0, 1'b0);
            end
            if (j == 16) begin
                chk("sw_rel0", rstn0, 1'b1);
                chk("sw_ack0", ack0, 1'b1);
            end
            if (j == 17) chk("sw_ackfall0", ack0, 1'b0);
        end

        #2 req0 = 1'b1;
        @(negedge clk);
        #2 req0 = 1'b0;
        repeat (9) @(negedge clk);
        #2 rn0 = 1'b0;
        #1;
        chk("abort_rstn0", rstn0, 1'b0);
        chk("abort_busy0", busy0, 1'b1);
        repeat (2) @(negedge clk);
        #2 rn0 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk("abort_noack0", ack0, 1'b0);
            chk("abort_rel0", rstn0, n >= 18);
            if (n == 4) #2 req0 = 1'b1;
            if (n == 15) #2 req0 = 1'b0;
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #2;
            req0 = ($urandom_range(0, 3) == 0);
            req1 = ($urandom_range(0, 3) == 0);
            if (lo0 > 0) begin
                lo0--;
                if (lo0 == 0) rn0 = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                rn0 = 1'b0;
                #1;
                chk("rnd_async0", rstn0, 1'b0);
                if ($urandom_range(0, 1) == 1) rn0 = 1'b1;
                else lo0 = int'($urandom_range(1, 3));
            end
            if (lo1 > 0) begin
                lo1--;
                if (lo1 == 0) rn1 = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                rn1 = 1'b0;
                #1;
                chk("rnd_async1", rstn1, 1'b0);
                if ($urandom_range(0, 1) == 1) rn1 = 1'b1;
                else lo1 = int'($urandom_range(1, 3));
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
